// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase control sequencer for the 8-bit accumulator CPU.
// Decodes the IR opcode and the ALU zero flag into mux, memory, register-load
// and PC strobes, latches HLT until reset, and counts retired instructions.
module cpu_sequencer #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [2:0]           opcode,
   input  logic                 zero,
   output logic                 sel,
   output logic                 rd,
   output logic                 ld_ir,
   output logic                 inc_pc,
   output logic                 ld_pc,
   output logic                 ld_ac,
   output logic                 wr,
   output logic                 data_e,
   output logic                 halt,
   output logic [2:0]           phase,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   // Opcode encoding shared with the ALU.
   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   phase_e               phase_q, phase_d;
   logic                 halted_q, halted_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 is_aluop;
   logic                 is_hlt;

   assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
   assign is_hlt   = (opcode == OP_HLT);

   // State register: phase, halt latch and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state: advance one phase per clock, stall in INST_ADDR without run,
   // freeze in OP_ADDR on HLT, count the instruction as STORE wraps to 0.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      phase_d  = phase_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      if (!halted_q) begin
         case (phase_q)
            INST_ADDR: begin
               if (run) phase_d = INST_FETCH;
            end
            OP_ADDR: begin
               if (is_hlt) halted_d = 1'b1;
               else        phase_d  = OP_FETCH;
            end
            STORE: begin
               phase_d = INST_ADDR;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
            default: phase_d = phase_e'(phase_q + 3'd1);
         endcase
      end
   end

   // Strobe decode from phase, opcode and zero; everything but halt is
   // silenced once the halt latch is set.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = halted_q || ((phase_q == OP_ADDR) && is_hlt);
      if (!halted_q) begin
         case (phase_q)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = !is_hlt;
            end
            OP_FETCH: begin
               rd = is_aluop;
            end
            ALU_OP: begin
               rd     = is_aluop;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            STORE: begin
               rd     = is_aluop;
               ld_ac  = is_aluop;
               ld_pc  = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: ;
         endcase
      end
   end

   assign phase       = phase_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: drives a 16-bit-counter and a 4-bit-counter sequencer with
// the same stimulus and checks both against a behavioural instruction model.
module tb_cpu_sequencer;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       run    = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       zero   = 1'b0;

   logic        sel16, rd16, ldir16, incpc16, ldpc16, ldac16, wr16, de16, halt16;
   logic [2:0]  ph16;
   logic [15:0] cnt16;
   logic        sel4, rd4, ldir4, incpc4, ldpc4, ldac4, wr4, de4, halt4;
   logic [2:0]  ph4;
   logic [3:0]  cnt4;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Behavioural model: where the instruction is, whether it halted, how many retired.
   int          m_phase  = 0;
   bit          m_halted = 1'b0;
   int unsigned m_cnt    = 0;

   cpu_sequencer #(.CNT_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
      .sel(sel16), .rd(rd16), .ld_ir(ldir16), .inc_pc(incpc16), .ld_pc(ldpc16),
      .ld_ac(ldac16), .wr(wr16), .data_e(de16), .halt(halt16), .phase(ph16),
      .instr_count(cnt16)
   );

   cpu_sequencer #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
      .sel(sel4), .rd(rd4), .ld_ir(ldir4), .inc_pc(incpc4), .ld_pc(ldpc4),
      .ld_ac(ldac4), .wr(wr4), .data_e(de4), .halt(halt4), .phase(ph4),
      .instr_count(cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase}.
   function automatic logic [11:0] model_out(input int ph, input bit hl,
                                             input logic [2:0] op, input logic z);
      bit aluop, s, r, li, ip, lp, la, w, de, h;
      aluop = (op >= 3'd2) && (op <= 3'd5);
      h  = hl || (ph == 4 && op == 3'd0);
      s  = 0; r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; de = 0;
      if (!hl) begin
         s  = (ph < 4);
         r  = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
         li = (ph == 2 || ph == 3);
         ip = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z);
         lp = (ph >= 6 && op == 3'd7);
         la = (ph == 7 && aluop);
         w  = (ph == 7 && op == 3'd6);
         de = (ph >= 6 && op == 3'd6);
      end
      return {s, r, li, ip, lp, la, w, de, h, 3'(ph)};
   endfunction

   // Model advance: an instruction moves forward one phase per clock.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  = 0;
         m_halted = 1'b0;
         m_cnt    = 0;
      end else if (!m_halted) begin
         if (m_phase == 0) begin
            if (run) m_phase = 1;
         end else if (m_phase == 4 && opcode == 3'd0) begin
            m_halted = 1'b1;
         end else if (m_phase == 7) begin
            m_phase = 0;
            m_cnt   = m_cnt + 1;
         end else begin
            m_phase = m_phase + 1;
         end
      end
   end

   // Compare both DUTs against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [11:0] e;
         logic [15:0] c16;
         logic [3:0]  c4;
         e   = model_out(m_phase, m_halted, opcode, zero);
         c16 = m_cnt[15:0];
         c4  = m_cnt[3:0];
         check("outs16", {sel16, rd16, ldir16, incpc16, ldpc16, ldac16, wr16, de16, halt16, ph16}, e);
         check("cnt16", cnt16, c16);
         check("outs4", {sel4, rd4, ldir4, incpc4, ldpc4, ldac4, wr4, de4, halt4, ph4}, e);
         check("cnt4", cnt4, c4);
      end
   end

   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (int'(ph16) != p && n < 40);
      check("wait_phase", ph16, p);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cnt_before;
      #1 rst_n = 1'b0;
      #2 chk_en = 1'b1;
      #9;
      check("rst_phase", ph16, 0);
      check("rst_sel", sel16, 1);
      check("rst_halt", halt16, 0);
      check("rst_cnt", cnt16, 0);
      #5 rst_n = 1'b1;

      // ADD: full 8-phase walk, accumulator load in phase 7, one retire.
      opcode = 3'd2; run = 1'b1;
      wait_phase(1); run = 1'b0;
      check("add_rd_p1", rd16, 1);
      wait_phase(5);
      check("add_rd_p5", rd16, 1);
      wait_phase(7);
      check("add_ldac_p7", ldac16, 1);
      wait_phase(0);
      check("add_count", cnt16, 1);

      // SKZ with zero=1 then zero=0.
      for (int zz = 1; zz >= 0; zz--) begin
         opcode = 3'd1; zero = 1'(zz); run = 1'b1;
         wait_phase(1); run = 1'b0;
         wait_phase(4);
         check("skz_incpc_p4", incpc16, 1);
         wait_phase(6);
         check("skz_incpc_p6", incpc16, zz);
         wait_phase(0);
      end

      // STO: data bus driven in 6-7, write only in 7, no reads after fetch.
      opcode = 3'd6; run = 1'b1;
      wait_phase(1); run = 1'b0;
      wait_phase(6);
      check("sto_de_p6", de16, 1);
      check("sto_wr_p6", wr16, 0);
      wait_phase(7);
      check("sto_wr_p7", wr16, 1);
      check("sto_rd_p7", rd16, 0);
      wait_phase(0);
      check("sto_count", cnt16, 4);

      // HLT: freezes at phase 4 for 20 clocks regardless of inputs.
      opcode = 3'd0; run = 1'b1;
      wait_phase(4);
      check("hlt_halt", halt16, 1);
      check("hlt_incpc", incpc16, 0);
      cnt_before = cnt16;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         opcode = 3'($urandom_range(1, 7));
         zero = 1'($urandom);
      end
      check("hlt_phase_held", ph16, 4);
      check("hlt_still", halt16, 1);
      check("hlt_cnt_frozen", cnt16, cnt_before);
      rst_n = 1'b0; #1;
      check("hlt_rst_phase", ph16, 0);
      check("hlt_rst_halt", halt16, 0);
      #1 rst_n = 1'b1;

      // run low holds phase 0; run dropped in phase 3 lets the instruction finish.
      run = 1'b0; opcode = 3'd2;
      repeat (5) @(negedge clk);
      #1;
      check("stall_phase", ph16, 0);
      check("stall_sel", sel16, 1);
      run = 1'b1;
      wait_phase(3); run = 1'b0;
      wait_phase(0);
      repeat (3) @(negedge clk);
      #1;
      check("stall_after_phase", ph16, 0);
      check("stall_after_cnt", cnt16, 1);

      // 16 back-to-back JMPs wrap the 4-bit counter.
      reset_pulse();
      opcode = 3'd7; run = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         wait_phase(6);
         check("jmp_ldpc_p6", ldpc16, 1);
         wait_phase(7);
         check("jmp_ldpc_p7", ldpc16, 1);
         wait_phase(0);
         if (i == 15) check("jmp_cnt4_15", cnt4, 15);
      end
      check("jmp_cnt4_wrap", cnt4, 0);
      check("jmp_cnt16", cnt16, 16);
      wait_phase(5);
      rst_n = 1'b0; #1;
      check("midrst_phase", ph16, 0);
      check("midrst_cnt", cnt16, 0);
      #1 rst_n = 1'b1;

      // Randomized run/opcode/zero with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         if (m_phase == 0 && !m_halted)
            opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         zero = 1'($urandom);
         run  = ($urandom_range(0, 3) != 0);
         if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 249) == 0)
            reset_pulse();
      end

      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
